// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-requester burst-locked round-robin arbiter.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

  // Smallest legal burst limit; smaller requests are clamped to this.
  localparam int unsigned MIN_MAX_BURST = 1;

  function automatic arb_state_e lock_state(req_idx_t k);
    return k ? StLock1 : StLock0;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for both requesters and the shared output channel.
interface mux2_rr_arbiter_if
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = 6
);

  logic              in0_valid;
  logic [DWIDTH-1:0] in0_data;
  logic              in0_last;
  logic              in0_ready;
  logic              in1_valid;
  logic [DWIDTH-1:0] in1_data;
  logic              in1_last;
  logic              in1_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;
  req_idx_t          out_src;

  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_last, out_src
  );

endinterface

// File: rtl/mux2_rr_arbiter_rr2_pick.sv
// Combinational grant selection from lock state, priority and request valids.
module mux2_rr_arbiter_rr2_pick
  import mux2_rr_arbiter_pkg::*;
(
  input  arb_state_e i_state,
  input  req_idx_t   i_prio,
  input  logic       i_in0_valid,
  input  logic       i_in1_valid,
  output req_idx_t   o_grant,
  output logic       o_grant_vld
);

  always_comb begin
    o_grant     = 1'b0;
    o_grant_vld = 1'b0;
    case (i_state)
      StIdle: begin
        o_grant_vld = i_in0_valid | i_in1_valid;
        o_grant     = (i_in0_valid & i_in1_valid) ? i_prio : i_in1_valid;
      end
      StLock0: begin
        o_grant_vld = 1'b1;
        o_grant     = 1'b0;
      end
      StLock1: begin
        o_grant_vld = 1'b1;
        o_grant     = 1'b1;
      end
      default: begin
        o_grant_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter with burst locking and a one-entry output register.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH    = 6,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  mux2_rr_arbiter_if.slave io_arb,
  output logic             o_err_overrun
);

  localparam int unsigned BURST = (MAX_BURST < MIN_MAX_BURST) ? MIN_MAX_BURST : MAX_BURST;
  localparam int unsigned CW    = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST);

  arb_state_e        r_state, w_state_nxt;
  req_idx_t          r_prio, w_prio_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_overrun, w_overrun_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [DWIDTH-1:0] r_out_data, w_out_data_nxt;
  logic              r_out_last, w_out_last_nxt;
  req_idx_t          r_out_src, w_out_src_nxt;

  req_idx_t          w_grant;
  logic              w_grant_vld;
  logic              w_can_load;
  logic              w_sel_valid;
  logic [DWIDTH-1:0] w_sel_data;
  logic              w_sel_last;
  logic              w_acc;
  logic              w_release;

  mux2_rr_arbiter_rr2_pick u_pick (
    .i_state    (r_state),
    .i_prio     (r_prio),
    .i_in0_valid(io_arb.in0_valid),
    .i_in1_valid(io_arb.in1_valid),
    .o_grant    (w_grant),
    .o_grant_vld(w_grant_vld)
  );

  always_comb begin
    w_can_load  = ~r_out_valid | io_arb.out_ready;
    w_sel_valid = w_grant ? io_arb.in1_valid : io_arb.in0_valid;
    w_sel_data  = w_grant ? io_arb.in1_data  : io_arb.in0_data;
    w_sel_last  = w_grant ? io_arb.in1_last  : io_arb.in0_last;
    w_acc       = w_can_load & w_grant_vld & w_sel_valid;
    w_cnt_inc   = r_cnt + 1'b1;
    w_release   = w_sel_last | (w_cnt_inc == BURST_LIM);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_prio_nxt      = r_prio;
    w_cnt_nxt       = r_cnt;
    w_overrun_nxt   = r_overrun;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_out_src_nxt   = r_out_src;
    if (w_acc) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = w_sel_data;
      w_out_last_nxt  = w_sel_last;
      w_out_src_nxt   = w_grant;
      if (w_release) begin
        w_state_nxt = StIdle;
        w_prio_nxt  = ~w_grant;
        w_cnt_nxt   = '0;
        // Hitting the limit without last means the producer overran its burst.
        if (!w_sel_last) begin
          w_overrun_nxt = 1'b1;
        end
      end else begin
        w_state_nxt = lock_state(w_grant);
        w_cnt_nxt   = w_cnt_inc;
      end
    end else if (io_arb.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_prio      <= 1'b0;
      r_cnt       <= '0;
      r_overrun   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prio      <= w_prio_nxt;
      r_cnt       <= w_cnt_nxt;
      r_overrun   <= w_overrun_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_src   <= w_out_src_nxt;
    end
  end

  assign io_arb.in0_ready = w_can_load & w_grant_vld & (w_grant == 1'b0);
  assign io_arb.in1_ready = w_can_load & w_grant_vld & (w_grant == 1'b1);
  assign io_arb.out_valid = r_out_valid;
  assign io_arb.out_data  = r_out_data;
  assign io_arb.out_last  = r_out_last;
  assign io_arb.out_src   = r_out_src;
  assign o_err_overrun    = r_overrun;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scenario bench for mux2_rr_arbiter with a transaction-level reference model.
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;

  localparam int unsigned DW = 6;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.DWIDTH(DW)) bus ();

  mux2_rr_arbiter #(
    .DWIDTH   (DW),
    .MAX_BURST(MB)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .io_arb       (bus),
    .o_err_overrun(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner of the channel (-1 = free), priority, beats so far.
  int          m_owner;
  int          m_prio;
  int          m_beats;
  bit          m_over;
  bit          m_ov;
  logic [DW-1:0] m_od;
  bit          m_ol;
  bit          m_os;

  // Per-cycle observations and expectations captured before the edge.
  bit          e_rdy0, e_rdy1, o_rdy0, o_rdy1, acc0, acc1;
  bit          o_emit;
  logic [DW-1:0] o_emit_data;
  bit          o_emit_src;

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_beats = 0; m_over = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
  endtask

  task automatic clear_inputs();
    bus.in0_valid = 0; bus.in0_data = '0; bus.in0_last = 0;
    bus.in1_valid = 0; bus.in1_data = '0; bus.in1_last = 0;
    bus.out_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic tick();
    int g;
    bit can, a_last, ordy;
    logic [DW-1:0] a_data;
    #1;
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else if (bus.in0_valid && bus.in1_valid) g = m_prio;
    else if (bus.in0_valid) g = 0;
    else if (bus.in1_valid) g = 1;
    ordy = bus.out_ready;
    can = !m_ov || ordy;
    e_rdy0 = can && (g == 0);
    e_rdy1 = can && (g == 1);
    acc0 = e_rdy0 && bus.in0_valid;
    acc1 = e_rdy1 && bus.in1_valid;
    a_data = acc1 ? bus.in1_data : bus.in0_data;
    a_last = acc1 ? bus.in1_last : bus.in0_last;
    o_rdy0 = bus.in0_ready;
    o_rdy1 = bus.in1_ready;
    o_emit = bus.out_valid && bus.out_ready;
    o_emit_data = bus.out_data;
    o_emit_src = bus.out_src;
    @(posedge clk);
    if (acc0 || acc1) begin
      g = acc1 ? 1 : 0;
      m_beats++;
      if (a_last || m_beats == MB) begin
        m_owner = -1; m_prio = 1 - g; m_beats = 0;
        if (!a_last) m_over = 1;
      end else begin
        m_owner = g;
      end
      m_ov = 1; m_od = a_data; m_ol = a_last; m_os = g[0];
    end else if (ordy) begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.out_valid, bus.out_last, bus.out_src, err} !== 4'b0)
      $display("FAIL reset_flags got v%b l%b s%b e%b want 0", bus.out_valid, bus.out_last,
               bus.out_src, err);
    n_checks++;
    if (bus.out_data !== '0) $display("FAIL reset_data got %h want 00", bus.out_data);
    tick();
    n_checks++;
    if (o_rdy0 !== 1'b0 || o_rdy1 !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_ready got %b%b want 00", o_rdy0, o_rdy1);
    end
    if ({bus.out_valid, bus.out_last, bus.out_src, err} !== 4'b0 || bus.out_data !== '0)
      n_errors++;
  endtask

  task automatic test_single_source();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.in0_valid = 1; bus.in0_data = DW'(i); bus.in0_last = (i == 3);
      tick();
      n_checks++;
      if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin
        n_errors++;
        $display("FAIL single_ready beat %0d got %b%b want 10", i, o_rdy0, o_rdy1);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i) || bus.out_src !== 1'b0 ||
          bus.out_last !== (i == 3)) begin
        n_errors++;
        $display("FAIL single_out beat %0d got v%b d%h s%b l%b want v1 d%h s0 l%b", i,
                 bus.out_valid, bus.out_data, bus.out_src, bus.out_last, DW'(i), (i == 3));
      end
    end
    bus.in0_valid = 0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_drain got v%b want 0", bus.out_valid);
    end
    bus.in0_valid = 1; bus.in0_data = 6'h09; bus.in0_last = 1;
    bus.in1_valid = 1; bus.in1_data = 6'h19; bus.in1_last = 1;
    tick();
    n_checks++;
    if (bus.out_src !== 1'b1 || o_rdy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL single_prio got src %b rdy1 %b want 1 1", bus.out_src, o_rdy1);
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.in0_valid = 1; bus.in0_data = 6'h0a; bus.in0_last = 1;
    bus.in1_valid = 1; bus.in1_data = 6'h15; bus.in1_last = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (o_rdy0 !== (i % 2 == 0) || o_rdy1 !== (i % 2 == 1)) begin
        n_errors++;
        $display("FAIL contention_ready cyc %0d got %b%b", i, o_rdy0, o_rdy1);
      end
      n_checks++;
      if (bus.out_src !== 1'((i % 2)) || bus.out_data !== ((i % 2) ? 6'h15 : 6'h0a)) begin
        n_errors++;
        $display("FAIL contention_src cyc %0d got s%b d%h want s%0d", i, bus.out_src,
                 bus.out_data, i % 2);
      end
    end
  endtask

  task automatic test_lock_hold();
    int b;
    bit [5:0] pat;
    b = 0;
    pat = 6'b110011;
    do_reset();
    bus.in1_valid = 1; bus.in1_data = 6'h20; bus.in1_last = 1;
    for (int c = 0; c < 6; c++) begin
      bus.in0_valid = pat[c]; bus.in0_data = DW'(b + 1); bus.in0_last = (b == 3);
      tick();
      n_checks++;
      if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin
        n_errors++;
        $display("FAIL lock_hold cyc %0d got %b%b want 10", c, o_rdy0, o_rdy1);
      end
      if (acc0) b++;
    end
    n_checks++;
    if (bus.out_data !== 6'h04 || bus.out_last !== 1'b1 || bus.out_src !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_last got d%h l%b s%b want d04 l1 s0", bus.out_data, bus.out_last,
               bus.out_src);
    end
    bus.in0_valid = 1; bus.in0_data = 6'h01; bus.in0_last = 1;
    tick();
    n_checks++;
    if (o_rdy1 !== 1'b1 || bus.out_src !== 1'b1 || bus.out_data !== 6'h20) begin
      n_errors++;
      $display("FAIL lock_next got rdy1 %b s%b d%h want 1 1 20", o_rdy1, bus.out_src,
               bus.out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in1_valid = 1; bus.in1_data = 6'h31; bus.in1_last = 0;
    tick();
    bus.in1_data = 6'h32;
    bus.in0_valid = 1; bus.in0_data = 6'h07; bus.in0_last = 1;
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (o_rdy0 !== 1'b0 || o_rdy1 !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 6'h31) begin
        n_errors++;
        $display("FAIL stall cyc %0d got rdy %b%b v%b d%h want 00 1 31", i, o_rdy0, o_rdy1,
                 bus.out_valid, bus.out_data);
      end
    end
    bus.out_ready = 1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      n_checks++;
      if (o_rdy1 !== 1'b1 || bus.out_data !== DW'(8'h30 + k) || !o_emit ||
          o_emit_data !== DW'(8'h30 + k - 1)) begin
        n_errors++;
        $display("FAIL resume beat %0d got rdy1 %b d%h emit %b/%h", k, o_rdy1, bus.out_data,
                 o_emit, o_emit_data);
      end
      bus.in1_data = DW'(8'h30 + k + 1);
    end
    tick();
    n_checks++;
    if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_count got rdy %b%b err %b want 10 1", o_rdy0, o_rdy1, err);
    end
  endtask

  task automatic test_overrun();
    int n1;
    bit expect_g0;
    n1 = 0;
    expect_g0 = 0;
    do_reset();
    bus.in1_valid = 1; bus.in1_data = 6'h11; bus.in1_last = 0;
    for (int c = 0; c < 30 && n1 < 6; c++) begin
      tick();
      n_checks++;
      if (o_rdy0 !== e_rdy0 || o_rdy1 !== e_rdy1) begin
        n_errors++;
        $display("FAIL overrun_ready cyc %0d got %b%b want %b%b", c, o_rdy0, o_rdy1, e_rdy0,
                 e_rdy1);
      end
      if (expect_g0) begin
        n_checks++;
        if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin
          n_errors++;
          $display("FAIL overrun_next_grant got %b%b want 10", o_rdy0, o_rdy1);
        end
        expect_g0 = 0;
      end
      if (acc1) begin
        n1++;
        n_checks++;
        if (err !== (n1 >= 4)) begin
          n_errors++;
          $display("FAIL overrun_flag beat %0d got %b want %b", n1, err, (n1 >= 4));
        end
        if (n1 == 4) expect_g0 = 1;
        bus.in1_data = DW'(8'h11 + n1);
      end
      bus.in0_valid = 1; bus.in0_data = 6'h05; bus.in0_last = 1;
    end
    n_checks++;
    if (n1 != 6) begin
      n_errors++;
      $display("FAIL overrun_progress got %0d beats want 6", n1);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.in1_valid = 1; bus.in1_data = 6'h2a; bus.in1_last = 0;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_last, bus.out_src, err} !== 4'b0 || bus.out_data !== '0) begin
      n_errors++;
      $display("FAIL async_reset got v%b d%h l%b s%b e%b want all 0", bus.out_valid,
               bus.out_data, bus.out_last, bus.out_src, err);
    end
    model_reset();
    bus.in0_valid = 1; bus.in0_data = 6'h03; bus.in0_last = 1;
    bus.in1_last = 1;
    #1;
    rst_n = 1;
    tick();
    n_checks++;
    if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0 || bus.out_src !== 1'b0 ||
        bus.out_data !== 6'h03) begin
      n_errors++;
      $display("FAIL post_reset_grant got rdy %b%b s%b d%h want 10 0 03", o_rdy0, o_rdy1,
               bus.out_src, bus.out_data);
    end
  endtask

  task automatic test_random();
    int tx0, tx1, rx0, rx1;
    tx0 = 0; tx1 = 0; rx0 = 0; rx1 = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!bus.in0_valid && $urandom_range(0, 2) != 0) begin
        bus.in0_valid = 1; bus.in0_data = DW'(tx0); bus.in0_last = ($urandom_range(0, 3) == 0);
      end
      if (!bus.in1_valid && $urandom_range(0, 2) != 0) begin
        bus.in1_valid = 1; bus.in1_data = DW'(tx1); bus.in1_last = ($urandom_range(0, 3) == 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (o_rdy0 !== e_rdy0 || o_rdy1 !== e_rdy1) begin
        n_errors++;
        $display("FAIL rand_ready cyc %0d got %b%b want %b%b", c, o_rdy0, o_rdy1, e_rdy0,
                 e_rdy1);
      end
      n_checks++;
      if (bus.out_valid !== m_ov || err !== m_over ||
          (m_ov && (bus.out_data !== m_od || bus.out_last !== m_ol || bus.out_src !== m_os)))
      begin
        n_errors++;
        $display("FAIL rand_out cyc %0d got v%b d%h l%b s%b e%b want v%b d%h l%b s%b e%b", c,
                 bus.out_valid, bus.out_data, bus.out_last, bus.out_src, err, m_ov, m_od, m_ol,
                 m_os, m_over);
      end
      if (o_emit) begin
        n_checks++;
        if (o_emit_data !== (o_emit_src ? DW'(rx1) : DW'(rx0))) begin
          n_errors++;
          $display("FAIL rand_order cyc %0d src %b got %h want %h", c, o_emit_src, o_emit_data,
                   o_emit_src ? DW'(rx1) : DW'(rx0));
        end
        if (o_emit_src) rx1++;
        else rx0++;
      end
      if (acc0) begin tx0++; bus.in0_valid = 0; end
      if (acc1) begin tx1++; bus.in1_valid = 0; end
    end
    n_checks++;
    if (rx0 + ((m_ov && !m_os) ? 1 : 0) != tx0 || rx1 + ((m_ov && m_os) ? 1 : 0) != tx1) begin
      n_errors++;
      $display("FAIL rand_count got rx %0d/%0d tx %0d/%0d", rx0, rx1, tx0, tx1);
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_source();
    test_contention();
    test_lock_hold();
    test_backpressure();
    test_overrun();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
